// File: rtl/alu_cmd_pkg.sv
// alu_cmd_pkg: shared types and default widths for the ALU command issuer.
package alu_cmd_pkg;

    localparam int W_DEF   = 8;
    localparam int OPW_DEF = 3;
    localparam int YW_DEF  = 16;

    // Issue sequencer states.
    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    // One queued ALU command at the default widths.
    typedef struct packed {
        logic [W_DEF-1:0]   a;
        logic [W_DEF-1:0]   b;
        logic [OPW_DEF-1:0] opc;
    } cmd_t;

endpackage

// File: rtl/alu_cmd_issuer_if.sv
// alu_cmd_issuer_if: command, ALU and result channels of the issuer.
// The master side is the driver/ALU environment; the slave side is the issuer.
interface alu_cmd_issuer_if #(
    parameter int w   = alu_cmd_pkg::W_DEF,
    parameter int OPW = alu_cmd_pkg::OPW_DEF,
    parameter int YW  = alu_cmd_pkg::YW_DEF
) ();

    logic           cmd_valid;
    logic           cmd_ready;
    logic [w-1:0]   cmd_a;
    logic [w-1:0]   cmd_b;
    logic [OPW-1:0] cmd_opc;

    logic [w-1:0]   alu_a;
    logic [w-1:0]   alu_b;
    logic [OPW-1:0] alu_opc;
    logic [YW-1:0]  alu_y;

    logic           res_valid;
    logic           res_ready;
    logic [YW-1:0]  res_y;

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_opc, alu_y, res_ready,
        input  cmd_ready, alu_a, alu_b, alu_opc, res_valid, res_y
    );

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_opc, alu_y, res_ready,
        output cmd_ready, alu_a, alu_b, alu_opc, res_valid, res_y
    );

endinterface

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: synchronous FIFO of DEPTH command items, head visible on dout.
// DEPTH must be a power of two so the pointers wrap naturally.
module alu_cmd_fifo
    import alu_cmd_pkg::*;
#(
    parameter type item_t = cmd_t,
    parameter int  DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  item_t                  din,
    input  logic                   pop,
    output item_t                  dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    item_t          mem [DEPTH];
    logic  [AW-1:0] wr_ptr;
    logic  [AW-1:0] rd_ptr;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    // Storage write on push.
    // NOTE: the storage array has no reset; only the pointers and count define
    // which entries are valid, so clearing it would just cost a reset net per bit.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; push and pop on one edge leave count alone.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: queues ALU commands, drives them one at a time onto a
// combinational ALU and returns each result over a valid/ready port.
// Optional build macro ALU_CMD_OPCNT_EN adds a saturating op_count output.
module alu_cmd_issuer
    import alu_cmd_pkg::*;
#(
    parameter int w     = W_DEF,
    parameter int OPW   = OPW_DEF,
    parameter int YW    = YW_DEF,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    alu_cmd_issuer_if.slave        bus
`ifdef ALU_CMD_OPCNT_EN
    ,
    output logic [15:0]            op_count
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [w-1:0]   a;
        logic [w-1:0]   b;
        logic [OPW-1:0] opc;
    } item_t;

    item_t           fifo_din;
    item_t           fifo_dout;
    logic            fifo_push;
    logic            fifo_pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;

    state_t          state;
    state_t          state_next;
    logic            capture_res;
    logic            release_res;

    // Ready comes only from the registered occupancy: a pop on the same edge
    // does not open a slot early, and nothing is taken while in reset.
    assign bus.cmd_ready = rst_n && !fifo_full;
    assign fifo_push     = bus.cmd_valid && bus.cmd_ready;
    assign fifo_din      = item_t'{a: bus.cmd_a, b: bus.cmd_b, opc: bus.cmd_opc};

    alu_cmd_fifo #(
        .item_t (item_t),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Next-state and control strobes for the IDLE -> EXEC -> RESP sequence.
    // NOTE: every output of this block gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_next  = state;
        fifo_pop    = 1'b0;
        capture_res = 1'b0;
        release_res = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                capture_res = 1'b1;
                state_next  = RESP;
            end
            RESP: begin
                if (bus.res_ready) begin
                    release_res = 1'b1;
                    if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        state_next = EXEC;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ALU operand registers (hold between pops) and the result holding register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.alu_a     <= '0;
            bus.alu_b     <= '0;
            bus.alu_opc   <= '0;
            bus.res_valid <= 1'b0;
            bus.res_y     <= '0;
        end else begin
            if (fifo_pop) begin
                bus.alu_a   <= fifo_dout.a;
                bus.alu_b   <= fifo_dout.b;
                bus.alu_opc <= fifo_dout.opc;
            end
            if (capture_res) begin
                bus.res_y     <= bus.alu_y;
                bus.res_valid <= 1'b1;
            end else if (release_res) begin
                bus.res_valid <= 1'b0;
            end
        end
    end

`ifdef ALU_CMD_OPCNT_EN
    // Completed-result counter, sticks at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (release_res && (op_count != 16'hFFFF)) begin
            op_count <= op_count + 16'd1;
        end
    end
`endif

    // Occupancy can never exceed the storage depth.
    count_in_range: assert property (
        @(posedge clk) disable iff (!rst_n) fifo_count <= CW'(DEPTH)
    );

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb_alu_cmd_issuer: scoreboard bench for alu_cmd_issuer with a behavioural ALU.
// Expected results are queued when a command handshake is seen and popped when
// a result handshake is seen. Build with ALU_CMD_OPCNT_EN to cover op_count.
module tb_alu_cmd_issuer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    alu_cmd_issuer_if #(.w(8), .OPW(3), .YW(16)) bus ();

`ifdef ALU_CMD_OPCNT_EN
    logic [15:0] op_count;
`endif

    alu_cmd_issuer #(
        .w     (8),
        .OPW   (3),
        .YW    (16),
        .DEPTH (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef ALU_CMD_OPCNT_EN
        ,
        .op_count (op_count)
`endif
    );

    int          n_total = 0;
    int          n_bad   = 0;
    int          n_res   = 0;
    logic [15:0] sb [$];

    // Behavioural ALU seen by the DUT.
    function automatic logic [15:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                              input logic [2:0] opc);
        case (opc)
            3'd0:    return 16'(a) + 16'(b);
            3'd1:    return 16'(a) - 16'(b);
            3'd2:    return 16'(a) * 16'(b);
            3'd3:    return {8'h00, a & b};
            3'd4:    return {8'h00, a | b};
            3'd5:    return {8'h00, a ^ b};
            3'd6:    return {8'h00, ~a};
            default: return {a, b};
        endcase
    endfunction

    assign bus.alu_y = alu_model(bus.alu_a, bus.alu_b, bus.alu_opc);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard monitor, sampling on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (bus.cmd_valid && bus.cmd_ready) begin
                sb.push_back(alu_model(bus.cmd_a, bus.cmd_b, bus.cmd_opc));
            end
            if (bus.res_valid && bus.res_ready) begin
                n_res++;
                if (sb.size() == 0) begin
                    check("res_unexpected", 32'(sb.size()), 1);
                end else begin
                    check("res_y", bus.res_y, sb.pop_front());
                end
            end
        end
    end

    // Present one command and keep it until accepted or the budget runs out.
    // Returns just after the accepting edge with cmd_valid still high.
    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [2:0] opc,
                         input int budget, output bit ok);
        bus.cmd_valid = 1'b1;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_opc   = opc;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.cmd_ready) ok = 1'b1;
            @(posedge clk);
            #1;
            if (ok) break;
        end
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] opc);
        bit ok;
        drive(a, b, opc, 100, ok);
        check("cmd_accept", 32'(ok), 1);
    endtask

    task automatic wait_drain(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (sb.size() == 0) break;
        end
        check(tag, 32'(sb.size()), 0);
    endtask

    // Global cycle budget.
    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog cycles got=20000 exp=below_20000");
        $fatal(1, "cycle budget exhausted");
    end

    initial begin
        bit          ok;
        int          accepted;
        int          base;
        logic [15:0] first_exp;

        // Reset with a command offered throughout.
        rst_n         = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_a     = 8'hAA;
        bus.cmd_b     = 8'h55;
        bus.cmd_opc   = 3'd0;
        bus.res_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", bus.cmd_ready, 0);
        check("rst_res_valid", bus.res_valid, 0);
        check("rst_alu_a", bus.alu_a, 0);
        check("rst_alu_b", bus.alu_b, 0);
        check("rst_alu_opc", bus.alu_opc, 0);
        check("rst_res_y", bus.res_y, 0);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        rst_n         = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_no_accept", bus.res_valid, 0);
        check("rst_idle_ready", bus.cmd_ready, 1);

        // Single op: latency and one-cycle result.
        @(posedge clk);
        #1;
        send(8'h05, 8'h03, 3'd0);
        bus.cmd_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("single_alu_a", bus.alu_a, 8'h05);
        check("single_alu_b", bus.alu_b, 8'h03);
        check("single_alu_opc", bus.alu_opc, 0);
        check("single_early_valid", bus.res_valid, 0);
        @(negedge clk);
        check("single_res_valid", bus.res_valid, 1);
        check("single_res_y", bus.res_y, 16'h0008);
        @(negedge clk);
        check("single_one_cycle", bus.res_valid, 0);

        // Backpressure until full.
        @(posedge clk);
        #1;
        bus.res_ready = 1'b0;
        first_exp     = alu_model(8'h10, 8'h20, 3'd0);
        accepted      = 0;
        for (int i = 0; i < 6; i++) begin
            drive(8'(8'h10 + i), 8'(8'h20 + i), 3'(i), (i < 5) ? 100 : 4, ok);
            if (ok) accepted++;
        end
        bus.cmd_valid = 1'b0;
        check("bp_accepted", 32'(accepted), 5);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_ready_low", bus.cmd_ready, 0);
            check("bp_res_valid", bus.res_valid, 1);
            check("bp_res_hold", bus.res_y, first_exp);
        end
        #1;
        base = n_res;
        @(posedge clk);
        #1;
        bus.res_ready = 1'b1;
        wait_drain("bp_drained", 40);
        check("bp_results", 32'(n_res - base), 5);
        @(negedge clk);
        check("bp_ready_back", bus.cmd_ready, 1);

        // Continuous stream with concurrent push and pop.
        @(posedge clk);
        #1;
        base = n_res;
        for (int i = 0; i < 20; i++) begin
            send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 3'($urandom_range(0, 7)));
        end
        bus.cmd_valid = 1'b0;
        wait_drain("stream_drained", 100);
        check("stream_results", 32'(n_res - base), 20);

        // Reset while in RESP with three commands queued.
        @(posedge clk);
        #1;
        bus.res_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(8'(8'h40 + i), 8'(8'h07 * i), 3'd2);
        end
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        check("mid_in_resp", bus.res_valid, 1);
        @(posedge clk);
        #1;
        rst_n         = 1'b0;
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_res_valid", bus.res_valid, 0);
        check("mid_alu_a", bus.alu_a, 0);
        check("mid_res_y", bus.res_y, 0);
        #1;
        base = n_res;
        repeat (6) @(negedge clk);
        #1;
        check("mid_no_stale", 32'(n_res - base), 0);
        @(posedge clk);
        #1;
        send(8'h21, 8'h0C, 3'd1);
        bus.cmd_valid = 1'b0;
        wait_drain("mid_drained", 20);
        check("mid_next_result", 32'(n_res - base), 1);

`ifdef ALU_CMD_OPCNT_EN
        // Operation counter: count then saturation.
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("opcnt_reset", op_count, 0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            send(8'(i), 8'(3 * i), 3'd0);
        end
        bus.cmd_valid = 1'b0;
        wait_drain("opcnt_drained", 60);
        @(negedge clk);
        check("opcnt_ten", op_count, 10);
        @(posedge clk);
        #1;
        force dut.op_count = 16'hFFFF;
        @(negedge clk);
        release dut.op_count;
        @(posedge clk);
        #1;
        send(8'h01, 8'h01, 3'd0);
        bus.cmd_valid = 1'b0;
        wait_drain("opcnt_sat_drained", 20);
        @(negedge clk);
        check("opcnt_saturate", op_count, 16'hFFFF);
`endif

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_cmd_issuer.md
Name: alu_cmd_issuer

Overview:
- Upstream stage for the combinational ALU.
- Accepts operand/opcode commands over a valid/ready handshake and buffers them in a small FIFO.
- Drives registered a/b/opc onto the ALU interface, samples the ALU result one cycle later, and presents it on a valid/ready result port.
- Decouples bench/driver timing from the ALU and gives the scoreboard a clean, one-result-per-command stream.

Parameters:
- w, 8, operand width; matches ALU `w`.
- OPW, 3, opcode width.
- YW, 16, ALU result width (2*w default, covers widening ops).
- DEPTH, 4, command FIFO depth; power of two, ≥2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command FIFO can accept.
- cmd_a  in  w  operand a.
- cmd_b  in  w  operand b.
- cmd_opc  in  OPW  opcode.
- alu_a  out  w  to ALU a.
- alu_b  out  w  to ALU b.
- alu_opc  out  OPW  to ALU opc.
- alu_y  in  YW  from ALU y.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_y  out  YW  captured result.

Behaviour:
- Reset: synchronous on a clk edge with rst_n=0. FIFO emptied, state IDLE, alu_a/alu_b/alu_opc=0, res_valid=0, res_y=0. cmd_ready=0 while rst_n=0.
- Reset mid-operation: in-flight and queued commands are discarded; no result is produced for them.
- Command accept: push on an edge with cmd_valid&&cmd_ready. cmd_ready = !full (registered count, no same-cycle bypass). When full, cmd_ready=0 even if a pop occurs that cycle.
- Commands with cmd_valid=0 are ignored; payload is don't-care.
- FSM states: IDLE, EXEC, RESP.
  - IDLE: if FIFO non-empty, pop head into alu_a/b/opc and go to EXEC. Else stay.
  - EXEC: alu_* are stable for a full cycle. On the next edge, res_y<=alu_y, res_valid<=1, go to RESP.
  - RESP: res_valid and res_y hold until res_valid&&res_ready. On that edge res_valid<=0. If FIFO is non-empty (count before any same-edge push), pop the next command and go to EXEC; else go to IDLE.
- alu_* hold their last value in IDLE/RESP; no glitching to 0.
- Latency: command accepted at edge N with an empty pipe gives pop at N+1 and res_valid=1 after edge N+2.
- Throughput: one result per 2 cycles with res_ready held high.
- Ordering: results are strictly in command order, one per command.
- Simultaneous push and pop in the same cycle: both are honoured and count is unchanged.
- Backpressure: res_ready=0 stalls in RESP. The FIFO keeps filling until full, then cmd_ready drops.
- FIFO pointers: log2(DEPTH) bits, natural wrap. Count is log2(DEPTH)+1 bits.
- No overflow or underflow is possible by construction. A push when full is impossible because cmd_ready=0.

Optional Feature:
- Macro: ALU_CMD_OPCNT_EN.
- With the macro: extra output op_count [15:0], reset 0. Increments on each res_valid&&res_ready handshake and saturates at 16'hFFFF.
- Without the macro: port absent, no counter logic.

Decomposition:
- Package alu_cmd_pkg contains:
  - state enum (IDLE, EXEC, RESP);
  - default width constants W_DEF=8, OPW_DEF=3, YW_DEF=16;
  - packed command struct {a, b, opc} parameterised via the widths.
- One sub-module: alu_cmd_fifo, a synchronous FIFO of DEPTH command structs with push/pop/full/empty/count.
- The top-level FSM and output registers stay in alu_cmd_issuer.

Test Plan:
- Reset check: hold rst_n=0 for 3 cycles with cmd_valid=1 → cmd_ready=0, res_valid=0, alu_a/b/opc=0, res_y=0. No command is accepted.
- Single op: bench ALU model y=a+b for opc=0; send a=8'h05, b=8'h03, opc=0, res_ready=1 → alu_a=05 and alu_b=03 one cycle after accept; res_valid=1 with res_y=16'h0008 two cycles after accept, for exactly one cycle.
- Backpressure/full: res_ready=0 and 6 back-to-back commands → first result is held stable. The FIFO absorbs 4 more and cmd_ready=0 afterwards. Releasing res_ready gives 5 results in order, then cmd_ready returns to 1.
- Simultaneous push/pop: keep FIFO at count 2 with res_ready=1 and a continuous cmd_valid stream → no command is lost and no result is duplicated. The scoreboard matches 20 commands to 20 in-order results.
- Reset mid-operation: pulse rst_n=0 for 1 cycle while in RESP with 3 queued commands → res_valid=0 after that edge, no result from the pre-reset commands, and the next accepted command produces the next result.
- With ALU_CMD_OPCNT_EN: 10 completed handshakes → op_count=10. Forcing the counter to 16'hFFFF then completing one more handshake → op_count stays 16'hFFFF.
